// File: rtl/led_write_sequencer.sv
// -----------------------------------------------------------------------------
// led_write_sequencer
//   Bus initiator for the LED register peripheral. On start (or a periodic
//   refresh tick) it snapshots the pattern and display-enable bit and issues
//   three paced single-cycle register writes: DATA_HI, DATA_LO, then CTRL, so
//   the display is enabled only after both data bytes are in place.
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   start         request one write sequence (level-sampled in IDLE)
//   refresh_en    enable periodic auto-refresh
//   pattern       LED pattern; [15:8] -> DATA_HI, [7:0] -> DATA_LO
//   display_on    value written to control bit0
//   write_enable  one-cycle write strobe
//   write_address register address (holds last strobed value)
//   write_data    register data (holds last strobed value)
//   busy          high while a sequence is in progress
//   done          one-cycle pulse when a sequence completes
// -----------------------------------------------------------------------------
module led_write_sequencer #(
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned REFRESH_CYCLES = 1000,
  parameter logic [7:0]  CTRL_ADDR      = 8'h01,
  parameter logic [7:0]  DATA_HI_ADDR   = 8'h02,
  parameter logic [7:0]  DATA_LO_ADDR   = 8'h03
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        refresh_en,
  input  logic [15:0] pattern,
  input  logic        display_on,
  output logic        write_enable,
  output logic [7:0]  write_address,
  output logic [7:0]  write_data,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW       = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [7:0]    GAP_LOAD = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    GAP,
    FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      step_q, step_d;
  logic [7:0]      gap_q, gap_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      pat_lo_q, pat_lo_d;
  logic            disp_q, disp_d;
  logic            we_q, we_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            refresh_tick;
  logic            launch;

  assign refresh_tick = refresh_en && (state_q == IDLE) && (cnt_q == REF_LAST);

  // Outputs are registered from the next-state decision, so the strobe is
  // visible in the same cycle the FSM sits in STROBE.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    gap_d    = gap_q;
    pat_lo_d = pat_lo_q;
    disp_d   = disp_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    launch   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start || refresh_tick) begin
          launch   = 1'b1;
          // Step 0 uses the live high byte; only the bytes needed later
          // are snapshotted.
          pat_lo_d = pattern[7:0];
          disp_d   = display_on;
          step_d   = 2'd0;
          state_d  = STROBE;
          we_d     = 1'b1;
          addr_d   = DATA_HI_ADDR;
          data_d   = pattern[15:8];
          busy_d   = 1'b1;
        end
      end
      STROBE: begin
        state_d = GAP;
        gap_d   = GAP_LOAD;
      end
      GAP: begin
        if (gap_q == 8'd0) begin
          if (step_q < 2'd2) begin
            step_d  = step_q + 2'd1;
            state_d = STROBE;
            we_d    = 1'b1;
            if (step_q == 2'd0) begin
              addr_d = DATA_LO_ADDR;
              data_d = pat_lo_q;
            end else begin
              addr_d = CTRL_ADDR;
              data_d = {7'b0, disp_q};
            end
          end else begin
            state_d = FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!refresh_en || launch) begin
      cnt_d = '0;
    end else if (state_q == IDLE) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      step_q   <= '0;
      gap_q    <= '0;
      cnt_q    <= '0;
      pat_lo_q <= '0;
      disp_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= CTRL_ADDR;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      gap_q    <= gap_d;
      cnt_q    <= cnt_d;
      pat_lo_q <= pat_lo_d;
      disp_q   <= disp_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign write_enable  = we_q;
  assign write_address = addr_q;
  assign write_data    = data_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
